// File: rtl/tessia_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// tessia_ctrl_pkg
// Shared types for the Tessia decode-stage control unit: opcode classes,
// data-processing commands, ALU operation codes, the decoded control word,
// the Execute-stage register image, the sequencer state, and a helper that
// sizes the beat counter from the unit parameters.
// ---------------------------------------------------------------------------
package tessia_ctrl_pkg;

   // Opcode classes carried in Op
   typedef enum logic [1:0] {
      OP_DP  = 2'b00,
      OP_MEM = 2'b01,
      OP_BR  = 2'b10,
      OP_ILL = 2'b11
   } op_e;

   // Data-processing commands carried in Funct[4:1]
   typedef enum logic [3:0] {
      CMD_ADD = 4'b0000,
      CMD_SUB = 4'b0001,
      CMD_MUL = 4'b0010,
      CMD_ORR = 4'b0011,
      CMD_MOD = 4'b0100,
      CMD_AND = 4'b0101,
      CMD_MOV = 4'b0110,
      CMD_DIV = 4'b0111,
      CMD_CMP = 4'b1000
   } cmd_e;

   // ALU operation codes driven into Execute
   localparam logic [3:0] ALU_ADD = 4'b0000;
   localparam logic [3:0] ALU_SUB = 4'b0001;
   localparam logic [3:0] ALU_MUL = 4'b0010;
   localparam logic [3:0] ALU_ORR = 4'b0011;
   localparam logic [3:0] ALU_MOD = 4'b0100;
   localparam logic [3:0] ALU_AND = 4'b0101;
   localparam logic [3:0] ALU_MOV = 4'b0110;
   localparam logic [3:0] ALU_DIV = 4'b0111;

   // Decoded control word for one instruction (before per-beat shaping)
   typedef struct packed {
      logic       reg_write;   // already gated by no_write
      logic       mem_write;
      logic       mem_to_reg;
      logic       branch;
      logic       alu_src;
      logic       no_write;
      logic       pc_dest;     // Rd == 15
      logic       vec;         // vector memory op, lanes advance per beat
      logic       multi_div;   // DIV/MOD, write-back only on last beat
      logic [3:0] alu_control;
   } ctrl_t;

   // Execute-stage register image
   typedef struct packed {
      logic       reg_write;
      logic       mem_write;
      logic       mem_to_reg;
      logic       branch;
      logic       alu_src;
      logic       no_write;
      logic       pc_src;
      logic       last_beat;
      logic       illegal;
      logic [3:0] alu_control;
   } estage_t;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_BUSY = 1'b1
   } state_e;

   // Beat counter width: enough to count to the longest sequence, minimum 1 bit
   function automatic int beat_width(input int lanes, input int mem_ports, input int div_lat);
      int m;
      m = 2;
      m = ((lanes / mem_ports) > m) ? (lanes / mem_ports) : m;
      m = (div_lat > m) ? div_lat : m;
      return $clog2(m);
   endfunction

endpackage

// File: rtl/vector_control_unit_if.sv
// ---------------------------------------------------------------------------
// vector_control_unit_if
// Bundles the Decode-side fields, hazard-unit controls and Execute-stage
// control outputs of the vector control unit.
//   master : pipeline/hazard side (drives ValidD, Op, Funct, Rd, StallE, FlushE)
//   slave  : control unit (drives ImmSrcD, RegSrcD, StallD and all *E outputs)
// LANES must match the LANES parameter of the attached control unit.
// ---------------------------------------------------------------------------
interface vector_control_unit_if #(
   parameter int LANES = 4
);
   localparam int LW = $clog2(LANES) + 1;

   logic          ValidD;
   logic [1:0]    Op;
   logic [5:0]    Funct;
   logic [3:0]    Rd;
   logic          StallE;
   logic          FlushE;

   logic [1:0]    ImmSrcD;
   logic [1:0]    RegSrcD;
   logic          StallD;
   logic          RegWriteE;
   logic          MemWriteE;
   logic          MemToRegE;
   logic          BranchE;
   logic          ALUSrcE;
   logic          NoWriteE;
   logic          PCSrcE;
   logic [3:0]    ALUControlE;
   logic [LW-1:0] LaneIdxE;
   logic          LastBeatE;
   logic          IllegalE;

   modport master (
      output ValidD, Op, Funct, Rd, StallE, FlushE,
      input  ImmSrcD, RegSrcD, StallD, RegWriteE, MemWriteE, MemToRegE, BranchE,
             ALUSrcE, NoWriteE, PCSrcE, ALUControlE, LaneIdxE, LastBeatE, IllegalE
   );

   modport slave (
      input  ValidD, Op, Funct, Rd, StallE, FlushE,
      output ImmSrcD, RegSrcD, StallD, RegWriteE, MemWriteE, MemToRegE, BranchE,
             ALUSrcE, NoWriteE, PCSrcE, ALUControlE, LaneIdxE, LastBeatE, IllegalE
   );

endinterface

// File: rtl/vcu_decoder.sv
// ---------------------------------------------------------------------------
// vcu_decoder
// Pure combinational decode of Op/Funct/Rd.
//   Op, Funct, Rd : Decode-stage instruction fields
//   ImmSrcD       : immediate select
//   RegSrcD       : register source select
//   ctrl          : decoded control word (ctrl_t)
//   nbeats        : number of Execute beats the instruction occupies
//   illegal       : undefined instruction (ctrl is all zero when set)
// ---------------------------------------------------------------------------
module vcu_decoder
   import tessia_ctrl_pkg::*;
#(
   parameter int LANES     = 4,
   parameter int MEM_PORTS = 1,
   parameter int DIV_LAT   = 8,
   localparam int BEAT_W   = beat_width(LANES, MEM_PORTS, DIV_LAT),
   localparam int NW       = BEAT_W + 1
) (
   input  logic [1:0]    Op,
   input  logic [5:0]    Funct,
   input  logic [3:0]    Rd,
   output logic [1:0]    ImmSrcD,
   output logic [1:0]    RegSrcD,
   output ctrl_t         ctrl,
   output logic [NW-1:0] nbeats,
   output logic          illegal
);

   // Instruction class and command decode
   always_comb begin
      ctrl         = '0;
      ImmSrcD      = 2'b00;
      RegSrcD      = 2'b00;
      nbeats       = NW'(1);
      illegal      = 1'b0;
      ctrl.pc_dest = (Rd == 4'd15);
      case (Op)
         OP_DP: begin
            ctrl.alu_src   = Funct[5];
            ctrl.reg_write = 1'b1;
            case (Funct[4:1])
               CMD_ADD: ctrl.alu_control = ALU_ADD;
               CMD_SUB: ctrl.alu_control = ALU_SUB;
               CMD_MUL: ctrl.alu_control = ALU_MUL;
               CMD_ORR: ctrl.alu_control = ALU_ORR;
               CMD_AND: ctrl.alu_control = ALU_AND;
               CMD_MOV: ctrl.alu_control = ALU_MOV;
               CMD_MOD: begin
                  ctrl.alu_control = ALU_MOD;
                  ctrl.multi_div   = 1'b1;
                  nbeats           = NW'(DIV_LAT);
               end
               CMD_DIV: begin
                  ctrl.alu_control = ALU_DIV;
                  ctrl.multi_div   = 1'b1;
                  nbeats           = NW'(DIV_LAT);
               end
               CMD_CMP: begin
                  // compare is a subtract whose result is discarded
                  ctrl.alu_control = ALU_SUB;
                  ctrl.no_write    = 1'b1;
                  ctrl.reg_write   = 1'b0;
               end
               default: begin
                  ctrl    = '0;
                  illegal = 1'b1;
               end
            endcase
         end
         OP_MEM: begin
            ImmSrcD      = 2'b01;
            ctrl.alu_src = 1'b1;
            ctrl.vec     = Funct[1];
            if (Funct[0]) begin
               ctrl.mem_to_reg  = 1'b1;
               ctrl.reg_write   = 1'b1;
               ctrl.alu_control = ALU_ADD;
            end else begin
               RegSrcD          = 2'b10;
               ctrl.mem_write   = 1'b1;
               // register-offset store subtracts its offset
               ctrl.alu_control = Funct[5] ? ALU_ADD : ALU_SUB;
            end
            if (Funct[1]) begin
               nbeats = NW'(LANES / MEM_PORTS);
            end else begin
               nbeats = NW'(1);
            end
         end
         OP_BR: begin
            RegSrcD          = 2'b01;
            ImmSrcD          = 2'b10;
            ctrl.alu_src     = 1'b1;
            ctrl.branch      = 1'b1;
            ctrl.alu_control = ALU_ADD;
         end
         default: begin
            ctrl    = '0;
            illegal = 1'b1;
         end
      endcase
   end

endmodule

// File: rtl/vector_control_unit.sv
// ---------------------------------------------------------------------------
// vector_control_unit
// Decode-stage control unit: decodes the instruction, owns the control half
// of the D->E register and sequences multi-cycle DIV/MOD and vector LDR/STR.
//   clk, reset : clock, synchronous active-high reset
//   bus        : vector_control_unit_if.slave (Decode fields, hazard
//                controls, StallD, ImmSrcD/RegSrcD and registered *E control)
// ---------------------------------------------------------------------------
module vector_control_unit
   import tessia_ctrl_pkg::*;
#(
   parameter int LANES     = 4,
   parameter int MEM_PORTS = 1,
   parameter int DIV_LAT   = 8
) (
   input  logic                  clk,
   input  logic                  reset,
   vector_control_unit_if.slave  bus
);

   localparam int BEAT_W = beat_width(LANES, MEM_PORTS, DIV_LAT);
   localparam int NW     = BEAT_W + 1;
   localparam int LW     = $clog2(LANES) + 1;

   ctrl_t             dec_ctrl_s;
   logic [NW-1:0]     dec_n_s;
   logic              dec_ill_s;

   state_e            state_r;
   logic [BEAT_W-1:0] cnt_r;
   ctrl_t             hold_ctrl_r;
   logic [NW-1:0]     hold_n_r;
   estage_t           e_r;
   logic [LW-1:0]     lane_r;

   ctrl_t             src_ctrl_s;
   logic [NW-1:0]     src_n_s;
   logic              src_ill_s;
   logic [BEAT_W-1:0] beat_s;
   logic              last_s;
   logic              rw_s;
   estage_t           nx_e_s;
   logic [LW-1:0]     nx_lane_s;

   vcu_decoder #(
      .LANES     (LANES),
      .MEM_PORTS (MEM_PORTS),
      .DIV_LAT   (DIV_LAT)
   ) u_dec (
      .Op      (bus.Op),
      .Funct   (bus.Funct),
      .Rd      (bus.Rd),
      .ImmSrcD (bus.ImmSrcD),
      .RegSrcD (bus.RegSrcD),
      .ctrl    (dec_ctrl_s),
      .nbeats  (dec_n_s),
      .illegal (dec_ill_s)
   );

   // Next-beat control: a fresh decode in IDLE (beat 0), the held instruction in BUSY
   always_comb begin
      src_ctrl_s = dec_ctrl_s;
      src_n_s    = dec_n_s;
      src_ill_s  = dec_ill_s;
      beat_s     = '0;
      if (state_r == ST_BUSY) begin
         src_ctrl_s = hold_ctrl_r;
         src_n_s    = hold_n_r;
         src_ill_s  = 1'b0;
         beat_s     = cnt_r + BEAT_W'(1);
      end else begin
         src_ctrl_s = dec_ctrl_s;
         src_n_s    = dec_n_s;
         src_ill_s  = dec_ill_s;
         beat_s     = '0;
      end
      last_s = ({1'b0, beat_s} == (src_n_s - NW'(1)));
      // DIV/MOD only writes back once the result exists
      rw_s   = src_ctrl_s.reg_write & (~src_ctrl_s.multi_div | last_s);

      nx_e_s.reg_write   = rw_s;
      nx_e_s.mem_write   = src_ctrl_s.mem_write;
      nx_e_s.mem_to_reg  = src_ctrl_s.mem_to_reg;
      nx_e_s.branch      = src_ctrl_s.branch;
      nx_e_s.alu_src     = src_ctrl_s.alu_src;
      nx_e_s.no_write    = src_ctrl_s.no_write;
      nx_e_s.pc_src      = last_s & ((src_ctrl_s.pc_dest & rw_s) | src_ctrl_s.branch);
      nx_e_s.last_beat   = last_s;
      nx_e_s.illegal     = src_ill_s;
      nx_e_s.alu_control = src_ctrl_s.alu_control;
      nx_lane_s = src_ctrl_s.vec ? LW'(LW'(beat_s) * LW'(MEM_PORTS)) : '0;
   end

   // Sequencer FSM and E-stage registers; flush and reset both abort to a bubble
   always_ff @(posedge clk) begin
      if (reset || bus.FlushE) begin
         state_r     <= ST_IDLE;
         cnt_r       <= '0;
         hold_ctrl_r <= '0;
         hold_n_r    <= '0;
         e_r         <= '0;
         lane_r      <= '0;
      end else if (bus.StallE) begin
         state_r <= state_r;
      end else begin
         case (state_r)
            ST_IDLE: begin
               if (bus.ValidD) begin
                  e_r    <= nx_e_s;
                  lane_r <= nx_lane_s;
                  if (dec_n_s > NW'(1)) begin
                     state_r     <= ST_BUSY;
                     cnt_r       <= '0;
                     hold_ctrl_r <= dec_ctrl_s;
                     hold_n_r    <= dec_n_s;
                  end
               end else begin
                  e_r    <= '0;
                  lane_r <= '0;
               end
            end
            ST_BUSY: begin
               e_r    <= nx_e_s;
               lane_r <= nx_lane_s;
               if (last_s) begin
                  state_r <= ST_IDLE;
                  cnt_r   <= '0;
               end else begin
                  cnt_r <= beat_s;
               end
            end
            default: begin
               state_r <= ST_IDLE;
               cnt_r   <= '0;
               e_r     <= '0;
               lane_r  <= '0;
            end
         endcase
      end
   end

   assign bus.StallD      = (state_r == ST_BUSY) | bus.StallE;
   assign bus.RegWriteE   = e_r.reg_write;
   assign bus.MemWriteE   = e_r.mem_write;
   assign bus.MemToRegE   = e_r.mem_to_reg;
   assign bus.BranchE     = e_r.branch;
   assign bus.ALUSrcE     = e_r.alu_src;
   assign bus.NoWriteE    = e_r.no_write;
   assign bus.PCSrcE      = e_r.pc_src;
   assign bus.ALUControlE = e_r.alu_control;
   assign bus.LaneIdxE    = lane_r;
   assign bus.LastBeatE   = e_r.last_beat;
   assign bus.IllegalE    = e_r.illegal;

endmodule
